// File: rtl/hdlc_tx_framer.sv
// hdlc_tx_framer: HDLC transmit framer with flags, zero insertion, abort pattern and idle fill
// Ports: Clk; Rst (synchronous, active-low).
//   Byte input: Tx_Data, Tx_Valid, Tx_Last, Tx_Ready (valid/ready handshake).
//   Tx_AbortFrame requests an abort; Tx is the registered serial line (LSB first).
//   Status: Tx_ValidFrame, Tx_Done, Tx_AbortedTrans, Tx_Underrun.
module hdlc_tx_framer #(
  parameter int MIN_IDLE_BITS = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Valid,
  input  logic       Tx_Last,
  output logic       Tx_Ready,
  input  logic       Tx_AbortFrame,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_Done,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Underrun
);
  localparam logic [7:0] FLAG = 8'h7E;
  localparam logic [7:0] MIN_IDLE = 8'(MIN_IDLE_BITS);
  typedef enum logic [2:0] {IDLE, FLAG_OPEN, DATA, FLAG_CLOSE, ABORT} state_t;
  state_t state, state_d;
  logic [2:0] bcnt, bcnt_d, ones, ones_d, ones_nx;
  logic [7:0] hold, sh, sh_d, idle_cnt, idle_inc;
  logic hold_full, hold_last, last_seen, sh_last, ins, ins_d, urun, rdy_en;
  logic load, accept, abort_req, enter_abort, close_end, in_frame, last_close, tx_d;
  // state and bcnt describe the bit currently on Tx; every *_d is the bit for the next cycle
  assign in_frame = state == FLAG_OPEN || state == DATA || state == FLAG_CLOSE;
  assign last_close = state == FLAG_CLOSE && bcnt == 3'd7;
  assign abort_req = Tx_AbortFrame && in_frame && !last_close;
  assign accept = Tx_Valid && Tx_Ready && !abort_req;
  assign enter_abort = state_d == ABORT && state != ABORT;
  assign close_end = state == FLAG_CLOSE && state_d == IDLE;
  assign idle_inc = idle_cnt == 8'hFF ? idle_cnt : idle_cnt + 8'd1;
  // run length including the data bit now on the line
  assign ones_nx = sh[0] ? ones + 3'd1 : 3'd0;
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
      bcnt <= 3'd0;
      ones <= 3'd0;
      ins <= 1'b0;
      sh <= 8'd0;
      sh_last <= 1'b0;
      hold <= 8'd0;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      last_seen <= 1'b0;
      urun <= 1'b0;
      rdy_en <= 1'b0;
      idle_cnt <= MIN_IDLE;
      Tx <= 1'b1;
    end else begin
      state <= state_d;
      bcnt <= bcnt_d;
      ones <= ones_d;
      ins <= ins_d;
      sh <= sh_d;
      Tx <= tx_d;
      rdy_en <= 1'b1;
      idle_cnt <= state == IDLE ? idle_inc : 8'd0;
      if (load) sh_last <= hold_last;
      hold_full <= !enter_abort && (accept || (hold_full && !load));
      if (accept) begin
        hold <= Tx_Data;
        hold_last <= Tx_Last;
      end
      last_seen <= !(enter_abort || close_end) && (last_seen || (accept && Tx_Last));
      if (enter_abort) urun <= !abort_req;
    end
  end
  always_comb begin
    state_d = state;
    bcnt_d = bcnt;
    ones_d = ones;
    ins_d = 1'b0;
    load = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full && idle_inc >= MIN_IDLE) begin
          state_d = FLAG_OPEN;
          bcnt_d = 3'd0;
          ones_d = 3'd0;
        end
      end
      FLAG_OPEN: begin
        bcnt_d = bcnt + 3'd1;
        if (bcnt == 3'd7) begin
          state_d = DATA;
          load = 1'b1;
        end
      end
      DATA: begin
        // a fifth consecutive 1 forces a stuffed 0 next; the shifter holds meanwhile
        ins_d = !ins && ones_nx == 3'd5;
        ones_d = ins ? ones : ins_d ? 3'd0 : ones_nx;
        if (!ins_d) begin
          bcnt_d = bcnt + 3'd1;
          if (bcnt == 3'd7) begin
            if (sh_last) state_d = FLAG_CLOSE;
            else if (hold_full) load = 1'b1;
            else state_d = ABORT;
          end
        end
      end
      default: begin
        bcnt_d = bcnt + 3'd1;
        if (bcnt == 3'd7) state_d = IDLE;
      end
    endcase
    if (abort_req) begin
      state_d = ABORT;
      bcnt_d = 3'd0;
      ins_d = 1'b0;
      load = 1'b0;
    end
  end
  always_comb begin
    sh_d = load ? hold : (state == DATA && !ins_d) ? sh >> 1 : sh;
    tx_d = state_d == IDLE ? 1'b1 :
           state_d == ABORT ? bcnt_d != 3'd0 :
           state_d == DATA ? !ins_d && sh_d[0] : FLAG[bcnt_d];
    Tx_ValidFrame = in_frame;
    Tx_Done = last_close;
    Tx_AbortedTrans = state == ABORT && bcnt == 3'd7;
    Tx_Underrun = Tx_AbortedTrans && urun;
    Tx_Ready = rdy_en && !hold_full && !last_seen && state != ABORT;
  end
endmodule

// File: tb/tb_hdlc_tx_framer.sv
// tb_hdlc_tx_framer: randomized self-checking bench comparing the line against a per-frame bit list
module tb_hdlc_tx_framer;
  localparam int MIN = 8;
  logic clk = 1'b0, rst = 1'b0, tx_valid = 1'b0, tx_last = 1'b0, tx_abort = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, tx, vf, done, abt, urun;
  int n_cmp = 0, n_err = 0, idle_ones = 0, rn = 0;
  logic [7:0] payload[$];
  logic [7:0] flag = 8'h7E;
  hdlc_tx_framer #(.MIN_IDLE_BITS(MIN)) dut (
    .Clk(clk),
    .Rst(rst),
    .Tx_Data(tx_data),
    .Tx_Valid(tx_valid),
    .Tx_Last(tx_last),
    .Tx_Ready(tx_ready),
    .Tx_AbortFrame(tx_abort),
    .Tx(tx),
    .Tx_ValidFrame(vf),
    .Tx_Done(done),
    .Tx_AbortedTrans(abt),
    .Tx_Underrun(urun)
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] obs();
    return {tx, vf, done, abt, urun};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, got, want);
    end
  endtask
  // expected line per frame cycle: {tx, valid_frame, done, aborted, underrun}
  task automatic run_frame(input bit use_last, input int abort_at, input int rst_at, input int gap);
    logic [4:0] exp_q[$];
    int ones = 0, bi = 0, idx = 0, since = -1, cyc = 0, ab = abort_at;
    int n = payload.size();
    bit started = 0, stop = 0, did_rst = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back({flag[i], 4'b1000});
    foreach (payload[b]) for (int j = 0; j < 8; j++) begin
      exp_q.push_back({payload[b][j], 4'b1000});
      ones = payload[b][j] ? ones + 1 : 0;
      if (ones == 5) begin
        exp_q.push_back(5'b01000);
        ones = 0;
      end
    end
    for (int i = 0; i < 8; i++)
      exp_q.push_back(use_last ? {flag[i], 1'b1, i == 7, 2'b00} : {i != 0, 2'b00, i == 7, i == 7});
    if (ab == -2) ab = exp_q.size() - 1;
    if (ab >= 0 && ab < exp_q.size() && exp_q[ab][3] && !exp_q[ab][2]) begin
      while (exp_q.size() > ab + 1) void'(exp_q.pop_back());
      for (int i = 0; i < 8; i++) exp_q.push_back({i != 0, 2'b00, i == 7, 1'b0});
    end
    repeat (gap) begin
      @(negedge clk);
      check("idle_gap", obs(), 5'b10000);
      idle_ones++;
      tx_valid = 1'b0;
      tx_abort = $urandom_range(0, 3) == 0;
    end
    while (!stop) begin
      @(negedge clk);
      if (!started && since >= 1 && idle_ones >= MIN) started = 1;
      if (started) begin
        check("line", obs(), exp_q[idx]);
        idx++;
      end else begin
        check("idle_wait", obs(), 5'b10000);
        idle_ones++;
        if (since >= 0) since++;
      end
      tx_abort = started && idx - 1 == ab;
      tx_valid = bi < n;
      tx_last = 1'b0;
      if (bi < n) begin
        tx_data = payload[bi];
        tx_last = use_last && bi == n - 1;
        if (tx_ready) begin
          bi++;
          if (since < 0) since = 0;
        end
      end
      if (tx_abort) bi = n;
      if (started && idx - 1 == rst_at) begin
        rst = 1'b0;
        tx_valid = 1'b0;
        tx_abort = 1'b0;
        did_rst = 1;
        stop = 1;
      end
      if (idx == exp_q.size()) begin
        stop = 1;
        idle_ones = 0;
      end
      if (++cyc > 3000) begin
        check("timeout", 1, 0);
        stop = 1;
      end
    end
    if (did_rst) begin
      @(negedge clk);
      check("rst_out", {obs(), tx_ready}, 6'b100000);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready", tx_ready, 1);
      check("rst_idle", obs(), 5'b10000);
      idle_ones = MIN;
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", {obs(), tx_ready}, 6'b100000);
    rst = 1'b1;
    @(negedge clk);
    check("ready_rise", tx_ready, 1);
    idle_ones = MIN;
    payload = '{8'h00};
    run_frame(1, -1, -1, 2);
    payload = '{8'hFF};
    run_frame(1, -1, -1, 0);
    payload = '{8'hF8, 8'h1F};
    run_frame(1, -1, -1, 0);
    payload = '{8'h11, 8'h22, 8'h33};
    run_frame(1, 19, -1, 3);
    payload = '{8'hA5};
    run_frame(0, -1, -1, 1);
    payload = '{8'h3C};
    run_frame(1, -2, -1, 4);
    payload = '{8'h7E, 8'h81};
    run_frame(1, 0, -1, 0);
    payload = '{8'h55, 8'hAA};
    run_frame(1, -1, 12, 2);
    repeat (60) begin
      rn = int'($urandom_range(1, 4));
      payload = {};
      repeat (rn) payload.push_back(8'($urandom));
      run_frame($urandom_range(0, 4) != 0,
                $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 8 + 10 * rn)) : -1,
                $urandom_range(0, 9) == 0 ? int'($urandom_range(1, 8 + 8 * rn)) : -1,
                int'($urandom_range(0, 10)));
    end
    repeat (10) begin
      @(negedge clk);
      check("tail_idle", obs(), 5'b10000);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
